reg_write_arbiter: RTL and testbench

Write-side arbiter for the register file's single write port. It merges two write sources: the in-order pipeline writeback stage, which has fixed priority and is never stalled, and a long-latency auxiliary source (multi-cycle mul/div, late load return) that uses a valid/ready handshake. Auxiliary writes are held in a small FIFO and drained into idle writeback slots. A pending-register mask is exported so the hazard unit can stall readers of registers whose writes are still queued.

---
 rtl/reg_write_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, aux writes queue in a FIFO.
// Optional REG_WRITE_SCOREBOARD_EN exports a per-register pending decode.
module reg_write_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_we,
  input  logic [4:0]                  wb_addr,
  input  logic [31:0]                 wb_data,
  input  logic                        aux_valid,
  input  logic [4:0]                  aux_addr,
  input  logic [31:0]                 aux_data,
  output logic                        aux_ready,
  output logic                        RegWrite,
  output logic [4:0]                  Write_register,
  output logic [31:0]                 Write_data,
  output logic [31:0]                 pending_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH-1:0] live_q, live_d;
  logic [4:0]            addr_q [FIFO_DEPTH];
  logic [4:0]            addr_d [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [31:0]           data_d [FIFO_DEPTH];

  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          empty;
  logic          full;
  logic          wb_used;
  logic          head_live;
  logic          push;
  logic          pop;

  assign head_idx  = rd_ptr_q[AW-1:0];
  assign tail_idx  = wr_ptr_q[AW-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign wb_used   = wb_we && (wb_addr != 5'd0);
  assign head_live = live_q[head_idx];

  assign aux_ready = reset && !full;
  // Zero-address handshakes are acknowledged but never stored
  assign push = aux_valid && aux_ready && (aux_addr != 5'd0);
  assign pop  = !empty && (!head_live || !wb_used);

  assign fifo_count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    live_d   = live_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // WB is younger than every queued write, so it supersedes them
    if (wb_used) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (addr_q[i] == wb_addr) begin
          live_d[i] = 1'b0;
        end
      end
    end
    if (pop) begin
      live_d[head_idx] = 1'b0;
      rd_ptr_d         = rd_ptr_q + PTR_ONE;
    end
    if (push) begin
      live_d[tail_idx] = 1'b1;
      addr_d[tail_idx] = aux_addr;
      data_d[tail_idx] = aux_data;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      live_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      live_q   <= live_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    RegWrite       = 1'b0;
    Write_register = '0;
    Write_data     = '0;
    if (reset) begin
      if (wb_used) begin
        RegWrite       = 1'b1;
        Write_register = wb_addr;
        Write_data     = wb_data;
      end else if (!empty && head_live) begin
        RegWrite       = 1'b1;
        Write_register = addr_q[head_idx];
        Write_data     = data_q[head_idx];
      end
    end
  end

`ifdef REG_WRITE_SCOREBOARD_EN
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q[i]) begin
        pending_mask[addr_q[i]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end
`else
  assign pending_mask = '0;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed vector table, reset sequence,
// and randomized traffic against a queue-based reference model.
module tb_reg_write_arbiter;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        aux_valid = 1'b0;
  logic [4:0]  aux_addr = '0;
  logic [31:0] aux_data = '0;
  logic        aux_ready;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [31:0] pending_mask;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  reg_write_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .aux_valid     (aux_valid),
    .aux_addr      (aux_addr),
    .aux_data      (aux_data),
    .aux_ready     (aux_ready),
    .RegWrite      (RegWrite),
    .Write_register(Write_register),
    .Write_data    (Write_data),
    .pending_mask  (pending_mask),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && RegWrite) rf[Write_register] <= Write_data;
  end

  typedef struct {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        rdy;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wdat;
    int          cnt;
    logic [31:0] mask;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic we, logic [4:0] wa, logic [31:0] wd,
    logic av, logic [4:0] aa, logic [31:0] ad,
    logic rdy, logic rw, logic [4:0] wr,
    logic [31:0] wdat, int cnt, logic [31:0] mask);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.av = av; v.aa = aa; v.ad = ad;
    v.rdy = rdy; v.rw = rw; v.wr = wr;
    v.wdat = wdat; v.cnt = cnt; v.mask = mask;
    return v;
  endfunction

  function automatic logic [31:0] sb(logic [31:0] m);
`ifdef REG_WRITE_SCOREBOARD_EN
    return m;
`else
    return 32'h0 & m;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd,
                       logic av, logic [4:0] aa, logic [31:0] ad);
    wb_we = we; wb_addr = wa; wb_data = wd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].addr] = 1'b1;
    m[0] = 1'b0;
    return sb(m);
  endfunction

  // Reference: check current outputs, then advance the queue one cycle
  task automatic model_step(string tag);
    logic        used;
    logic        rdy;
    logic        erw;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic        do_pop;
    ent_t        e;
    used = wb_we && (wb_addr != 0);
    rdy = (q.size() < D);
    erw = 0; ewr = 0; ewd = 0;
    if (used) begin
      erw = 1; ewr = wb_addr; ewd = wb_data;
    end else if (q.size() > 0 && q[0].live) begin
      erw = 1; ewr = q[0].addr; ewd = q[0].data;
    end
    chk({tag, "_ready"}, aux_ready, rdy);
    chk({tag, "_regwrite"}, RegWrite, erw);
    chk({tag, "_wreg"}, Write_register, ewr);
    chk({tag, "_wdata"}, Write_data, ewd);
    chk({tag, "_count"}, fifo_count, q.size());
    chk({tag, "_mask"}, pending_mask, model_mask());
    do_pop = (q.size() > 0) && (!q[0].live || !used);
    if (used) foreach (q[i]) if (q[i].addr == wb_addr) q[i].live = 0;
    if (do_pop) void'(q.pop_front());
    if (aux_valid && rdy && aux_addr != 0) begin
      e.live = 1; e.addr = aux_addr; e.data = aux_data;
      q.push_back(e);
    end
  endtask

  initial begin
    foreach (rf[i]) rf[i] = '0;

    // Reset state, with WB inputs active
    drive(1, 5'd4, 32'hDEAD, 1, 5'd6, 32'h1);
    #1;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wreg", Write_register, 0);
    chk("rst_wdata", Write_data, 0);
    chk("rst_ready", aux_ready, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_mask", pending_mask, 0);
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Single push r5
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0));
    tv.push_back(mk(0,0,0, 1,5,32'h1234, 1,0,0,0, 0,0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1,5,32'h1234, 1,32'h20));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0));
    // WB r8 busy while r9..r12 queue, then drain
    tv.push_back(mk(1,8,32'hA, 1,9,32'h99, 1,1,8,32'hA, 0,0));
    tv.push_back(mk(1,8,32'hA, 1,10,32'hAA, 1,1,8,32'hA, 1,32'h200));
    tv.push_back(mk(1,8,32'hA, 1,11,32'hBB, 1,1,8,32'hA, 2,32'h600));
    tv.push_back(mk(1,8,32'hA, 1,12,32'hCC, 1,1,8,32'hA, 3,32'hE00));
    tv.push_back(mk(1,8,32'hA, 1,13,32'hDD, 0,1,8,32'hA, 4,32'h1E00));
    tv.push_back(mk(0,0,0, 0,0,0, 0,1,9,32'h99, 4,32'h1E00));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1,10,32'hAA, 3,32'h1C00));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1,11,32'hBB, 2,32'h1800));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1,12,32'hCC, 1,32'h1000));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0));
    // Kill: r7 queued behind busy WB, then WB writes r7
    tv.push_back(mk(1,8,32'hA, 1,7,32'h1, 1,1,8,32'hA, 0,0));
    tv.push_back(mk(1,7,32'h2, 0,0,0, 1,1,7,32'h2, 1,32'h80));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 1,0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0));
    // Same-cycle WB r3 and aux r3
    tv.push_back(mk(1,3,32'h3, 1,3,32'h4, 1,1,3,32'h3, 0,0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1,3,32'h4, 1,32'h8));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0));
    // Zero-address aux handshake
    tv.push_back(mk(0,0,0, 1,0,32'h55, 1,0,0,0, 0,0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,0,0, 0,0));
    // WB to r0 is not a used slot
    tv.push_back(mk(1,0,32'h77, 0,0,0, 1,0,0,0, 0,0));

    foreach (tv[k]) begin
      string n;
      @(negedge clk);
      drive(tv[k].we, tv[k].wa, tv[k].wd,
            tv[k].av, tv[k].aa, tv[k].ad);
      #1;
      n = $sformatf("vec%0d", k);
      chk({n, "_ready"}, aux_ready, tv[k].rdy);
      chk({n, "_regwrite"}, RegWrite, tv[k].rw);
      chk({n, "_wreg"}, Write_register, tv[k].wr);
      chk({n, "_wdata"}, Write_data, tv[k].wdat);
      chk({n, "_count"}, fifo_count, tv[k].cnt);
      chk({n, "_mask"}, pending_mask, sb(tv[k].mask));
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rf_r7_final", rf[7], 32'h2);
    chk("rf_r3_final", rf[3], 32'h4);

    // Reset with three live entries queued behind busy WB
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 5'd1, 32'h11, 1, 5'(20 + i), 32'h100 + i);
    end
    @(negedge clk);
    drive(1, 5'd1, 32'h11, 0, 0, 0);
    #1;
    chk("pre_rst_count", fifo_count, 3);
    chk("pre_rst_mask", pending_mask, sb(32'h0070_0000));
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_mask", pending_mask, 0);
    chk("mid_rst_regwrite", RegWrite, 0);
    chk("mid_rst_ready", aux_ready, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_regwrite", RegWrite, 0);
      chk("post_rst_count", fifo_count, 0);
      @(negedge clk);
    end

    // Randomized traffic against the queue model
    q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive(($urandom_range(0, 99) < 55),
            5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 99) < 60),
            5'($urandom_range(0, 7)), $urandom());
      #1;
      model_step("rnd");
    end

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
